// File: rtl/timer_counter_multi_if.sv
// APB slave bus bundle for the multi-channel timer/counter.
interface timer_counter_multi_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_counter_multi.sv
// NUM_CH independent up/down timers behind one zero-wait-state APB slave.
// A shared 4-bit free-running prescaler produces phase-aligned tick enables.
module timer_counter_multi #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                 pclk,
  input  logic                 preset,
  timer_counter_multi_if.slave bus,
  output logic [NUM_CH-1:0]    tmr_ovf,
  output logic [NUM_CH-1:0]    tmr_udf,
  output logic                 irq
);

  localparam int unsigned ChW = ADDR_WIDTH - 2;

  // Register offsets within a channel
  localparam logic [1:0] OffTdr  = 2'd0;
  localparam logic [1:0] OffTcr  = 2'd1;
  localparam logic [1:0] OffTsr  = 2'd2;
  localparam logic [1:0] OffTcnt = 2'd3;

  logic [ChW-1:0] ch_idx;
  logic [1:0]     reg_off;
  logic           ch_valid;
  logic           access;
  logic           wr_commit;

  logic [3:0]            pc_q;
  logic [DATA_WIDTH-1:0] tdr_q [NUM_CH];
  logic [DATA_WIDTH-1:0] tdr_d [NUM_CH];
  logic [DATA_WIDTH-1:0] cnt_q [NUM_CH];
  logic [DATA_WIDTH-1:0] cnt_d [NUM_CH];
  // TCR bits 6:0 only; LOAD is a write strobe and is never stored
  logic [6:0]            tcr_q [NUM_CH];
  logic [6:0]            tcr_d [NUM_CH];
  logic [NUM_CH-1:0]     ovf_q, ovf_d, udf_q, udf_d;

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] set_ovf, set_udf;
  logic [NUM_CH-1:0] ovf_ie, udf_ie;

  assign ch_idx    = bus.paddr[ADDR_WIDTH-1:2];
  assign reg_off   = bus.paddr[1:0];
  assign ch_valid  = 32'(ch_idx) < NUM_CH;
  assign access    = bus.psel & bus.penable;
  // TCNT is read-only, so a write to it never commits
  assign wr_commit = access & bus.pwrite & ch_valid & (reg_off != OffTcnt);

  assign bus.pready  = 1'b1;
  assign bus.pslverr = access & (~ch_valid | (bus.pwrite & (reg_off == OffTcnt)));

  // Per-channel write select and prescaler tick decode
  always_comb begin
    wr_sel = '0;
    tick   = '0;
    ovf_ie = '0;
    udf_ie = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_commit & (ch_idx == ChW'(i));
      ovf_ie[i] = tcr_q[i][3];
      udf_ie[i] = tcr_q[i][2];
      case (tcr_q[i][1:0])
        2'd0:    tick[i] = pc_q[0];
        2'd1:    tick[i] = &pc_q[1:0];
        2'd2:    tick[i] = &pc_q[2:0];
        default: tick[i] = &pc_q;
      endcase
    end
  end

  // Register writes, counter update and sticky flag next-state
  always_comb begin
    load    = '0;
    set_ovf = '0;
    set_udf = '0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      tdr_d[i] = tdr_q[i];
      tcr_d[i] = tcr_q[i];
      cnt_d[i] = cnt_q[i];
      if (wr_sel[i] && reg_off == OffTdr) begin
        tdr_d[i] = bus.pwdata;
      end
      if (wr_sel[i] && reg_off == OffTcr) begin
        tcr_d[i] = bus.pwdata[6:0];
        load[i]  = bus.pwdata[7];
      end
      // LOAD takes the pre-edge TDR and masks any tick on the same edge
      if (load[i]) begin
        cnt_d[i] = tdr_q[i];
      end else if (tcr_q[i][4] && tick[i]) begin
        if (!tcr_q[i][5]) begin
          if (&cnt_q[i]) begin
            cnt_d[i]   = tcr_q[i][6] ? tdr_q[i] : '0;
            set_ovf[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DATA_WIDTH'(1);
          end
        end else begin
          if (cnt_q[i] == '0) begin
            cnt_d[i]   = tcr_q[i][6] ? tdr_q[i] : '1;
            set_udf[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - DATA_WIDTH'(1);
          end
        end
      end
      // Hardware set beats a simultaneous W1C
      if (wr_sel[i] && reg_off == OffTsr) begin
        ovf_d[i] = ovf_q[i] & ~bus.pwdata[0];
        udf_d[i] = udf_q[i] & ~bus.pwdata[1];
      end
      ovf_d[i] = ovf_d[i] | set_ovf[i];
      udf_d[i] = udf_d[i] | set_udf[i];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      pc_q  <= 4'd0;
      ovf_q <= '0;
      udf_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tdr_q[i] <= '0;
        tcr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_q + 4'd1;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tdr_q[i] <= tdr_d[i];
        tcr_q[i] <= tcr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Combinational read mux; invalid channels and non-read cycles return 0
  always_comb begin
    bus.prdata = '0;
    if (bus.psel && !bus.pwrite && ch_valid) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == ChW'(i)) begin
          case (reg_off)
            OffTdr:  bus.prdata = tdr_q[i];
            OffTcr:  bus.prdata = {{(DATA_WIDTH-7){1'b0}}, tcr_q[i]};
            OffTsr:  bus.prdata = {{(DATA_WIDTH-2){1'b0}}, udf_q[i], ovf_q[i]};
            default: bus.prdata = cnt_q[i];
          endcase
        end
      end
    end
  end

  assign tmr_ovf = ovf_q;
  assign tmr_udf = udf_q;
  assign irq     = |((ovf_q & ovf_ie) | (udf_q & udf_ie));

endmodule

// File: tb/tb_timer_counter_multi.sv
// Directed + randomized bench for timer_counter_multi against a cycle-level reference model.
module tb_timer_counter_multi;

  localparam int NCH  = 2;
  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int MAXV = 255;

  logic           pclk;
  logic           preset;
  logic [NCH-1:0] tmr_ovf, tmr_udf;
  logic           irq;

  timer_counter_multi_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  timer_counter_multi #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NCH),
    .ADDR_WIDTH(AW)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus),
    .tmr_ovf(tmr_ovf),
    .tmr_udf(tmr_udf),
    .irq    (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model: register contents as plain integers, cycles since reset
  int unsigned m_tdr [NCH];
  int unsigned m_tcr [NCH];
  int unsigned m_cnt [NCH];
  bit          m_ovf [NCH];
  bit          m_udf [NCH];
  int unsigned m_cyc;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_rd();
    int unsigned ch, off;
    ch  = int'(bus.paddr) / 4;
    off = int'(bus.paddr) % 4;
    if (!(bus.psel && !bus.pwrite) || ch >= NCH) return 0;
    case (off)
      0:       return m_tdr[ch];
      1:       return m_tcr[ch];
      2:       return (int'(m_udf[ch]) * 2) + int'(m_ovf[ch]);
      default: return m_cnt[ch];
    endcase
  endfunction

  function automatic bit exp_err();
    int unsigned ch, off;
    ch  = int'(bus.paddr) / 4;
    off = int'(bus.paddr) % 4;
    return bus.psel && bus.penable && (ch >= NCH || (bus.pwrite && off == 3));
  endfunction

  task automatic check_all();
    logic [NCH-1:0] eo, eu;
    logic           ei;
    ei = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      eo[i] = m_ovf[i];
      eu[i] = m_udf[i];
      if (m_ovf[i] && ((m_tcr[i] / 8) % 2 == 1)) ei = 1'b1;
      if (m_udf[i] && ((m_tcr[i] / 4) % 2 == 1)) ei = 1'b1;
    end
    chk("tmr_ovf", 32'(tmr_ovf), 32'(eo));
    chk("tmr_udf", 32'(tmr_udf), 32'(eu));
    chk("irq", 32'(irq), 32'(ei));
    chk("pready", 32'(bus.pready), 32'd1);
    chk("pslverr", 32'(bus.pslverr), 32'(exp_err()));
    chk("prdata", 32'(bus.prdata), exp_rd());
  endtask

  // One pclk edge: model next state from pre-edge state and driven inputs
  task automatic cyc();
    int unsigned n_tdr [NCH];
    int unsigned n_tcr [NCH];
    int unsigned n_cnt [NCH];
    bit          n_ovf [NCH];
    bit          n_udf [NCH];
    int unsigned ch, off;
    bit          wr;
    ch  = int'(bus.paddr) / 4;
    off = int'(bus.paddr) % 4;
    wr  = bus.psel && bus.penable && bus.pwrite && ch < NCH;
    for (int i = 0; i < NCH; i++) begin
      bit          ld, so, su, clr_o, clr_u, en, down, arld, tk;
      int unsigned per;
      ld = 0; so = 0; su = 0; clr_o = 0; clr_u = 0;
      n_tdr[i] = m_tdr[i];
      n_tcr[i] = m_tcr[i];
      n_cnt[i] = m_cnt[i];
      if (wr && ch == i) begin
        case (off)
          0: n_tdr[i] = int'(bus.pwdata);
          1: begin
            n_tcr[i] = int'(bus.pwdata) % 128;
            ld       = int'(bus.pwdata) >= 128;
          end
          2: begin
            clr_o = bus.pwdata[0];
            clr_u = bus.pwdata[1];
          end
          default: ;
        endcase
      end
      en   = (m_tcr[i] / 16) % 2 == 1;
      down = (m_tcr[i] / 32) % 2 == 1;
      arld = (m_tcr[i] / 64) % 2 == 1;
      per  = 2 ** ((m_tcr[i] % 4) + 1);
      tk   = (m_cyc % per) == per - 1;
      if (ld) begin
        n_cnt[i] = m_tdr[i];
      end else if (en && tk) begin
        if (!down) begin
          if (m_cnt[i] + 1 > MAXV) begin
            n_cnt[i] = arld ? m_tdr[i] : 0;
            so = 1;
          end else n_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            n_cnt[i] = arld ? m_tdr[i] : MAXV;
            su = 1;
          end else n_cnt[i] = m_cnt[i] - 1;
        end
      end
      n_ovf[i] = (m_ovf[i] && !clr_o) || so;
      n_udf[i] = (m_udf[i] && !clr_u) || su;
    end
    @(posedge pclk);
    if (preset) begin
      m_cyc = 0;
      for (int i = 0; i < NCH; i++) begin
        m_tdr[i] = 0; m_tcr[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
      end
    end else begin
      m_cyc++;
      for (int i = 0; i < NCH; i++) begin
        m_tdr[i] = n_tdr[i]; m_tcr[i] = n_tcr[i]; m_cnt[i] = n_cnt[i];
        m_ovf[i] = n_ovf[i]; m_udf[i] = n_udf[i];
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
    cyc();
    bus.penable = 1'b1;
    cyc();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [DW-1:0] val);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
    #1;
    chk("rd_setup", 32'(bus.prdata), exp_rd());
    cyc();
    bus.penable = 1'b1;
    #1;
    chk("rd_access", 32'(bus.prdata), exp_rd());
    chk("rd_err", 32'(bus.pslverr), 32'(exp_err()));
    val = bus.prdata;
    cyc();
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v;
    bit            found;
    vectors = 0; miscompares = 0; m_cyc = 0;
    for (int i = 0; i < NCH; i++) begin
      m_tdr[i] = 0; m_tcr[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
    end
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    preset = 1'b1;
    idle(2);
    preset = 1'b0;

    // Reset state of all registers on ch0 and ch1
    for (int a = 0; a < 8; a++) begin
      apb_read(AW'(a), v);
      chk("reset_reg", 32'(v), 32'd0);
    end

    // ch0 up-count from 0xFA to overflow
    apb_write(5'd0, 8'hFA);
    apb_write(5'd1, 8'h80);
    apb_write(5'd1, 8'h10);
    idle(20);
    chk("ch0_ovf_set", 32'(tmr_ovf[0]), 32'd1);

    // ch1 down-count with auto-reload and UDFIE
    apb_write(5'd4, 8'h03);
    apb_write(5'd5, 8'hE1);
    apb_write(5'd5, 8'h75);
    idle(18);
    chk("ch1_udf_set", 32'(tmr_udf[1]), 32'd1);
    chk("ch1_irq", 32'(irq), 32'd1);
    apb_read(5'd5, v);
    chk("ch1_tcr_rd", 32'(v), 32'h75);

    // Quiesce ch1, then W1C racing frequent ch0 overflows
    apb_write(5'd5, 8'h00);
    apb_write(5'd6, 8'h02);
    apb_write(5'd0, 8'hFE);
    apb_write(5'd1, 8'h80);
    apb_write(5'd1, 8'h58);
    for (int k = 0; k < 8; k++) begin
      apb_write(5'd2, 8'h01);
      idle(k % 4);
    end
    apb_write(5'd1, 8'h08);
    idle(2);
    apb_write(5'd2, 8'h01);
    chk("w1c_ovf_clr", 32'(tmr_ovf[0]), 32'd0);
    chk("w1c_irq_drop", 32'(irq), 32'd0);

    // Error responses: TCNT write, out-of-range channels
    apb_write(5'd3, 8'h55);
    apb_read(5'd3, v);
    apb_write(5'd8, 8'h12);
    apb_read(5'd8, v);
    chk("bad_ch_rd", 32'(v), 32'd0);
    apb_read(5'd31, v);
    apb_read(5'd0, v);
    chk("tdr_kept", 32'(v), 32'hFE);

    // Randomized APB traffic
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 1) apb_write(AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)));
      else apb_read(AW'($urandom_range(0, 31)), v);
      idle($urandom_range(0, 3));
    end

    // Reset mid-count on ch1
    apb_write(5'd1, 8'h00);
    apb_write(5'd5, 8'h00);
    apb_write(5'd4, 8'h03);
    apb_write(5'd5, 8'hE1);
    apb_write(5'd5, 8'h75);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_cnt[1] == 2) found = 1;
      else cyc();
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL wait_cnt2: observed %0d expected 2", m_cnt[1]);
    end
    preset = 1'b1;
    cyc();
    preset = 1'b0;
    chk("rst_udf", 32'(tmr_udf), 32'd0);
    apb_read(5'd7, v);
    chk("rst_tcnt", 32'(v), 32'd0);
    apb_read(5'd5, v);
    chk("rst_tcr", 32'(v), 32'd0);
    idle(20);
    apb_read(5'd7, v);
    chk("rst_no_count", 32'(v), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_counter_multi.md
Name: timer_counter_multi

Overview:
- Parametrised successor to the 8-bit APB timer/counter.
- NUM_CH independent up/down timer channels of DATA_WIDTH bits, behind one APB slave.
- One internal free-running prescaler replaces the external divided-clock bus; everything runs on pclk with tick enables.
- Adds auto-reload, per-channel W1C status, interrupt enables, a readable live count and a combined irq.

Parameters:
- DATA_WIDTH, 8, counter/register/APB data width; must be >= 8.
- NUM_CH, 2, number of timer channels, 1..8.
- ADDR_WIDTH, 5, APB address width; must be >= 2 + clog2(NUM_CH).

Ports:
- pclk  in  1  system clock; all state on rising edge.
- preset  in  1  synchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  {channel index, reg offset[1:0]}.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  always 1 (zero wait states).
- pslverr  out  1  error response.
- tmr_ovf  out  NUM_CH  per-channel sticky overflow flag.
- tmr_udf  out  NUM_CH  per-channel sticky underflow flag.
- irq  out  1  OR over channels of (ovf & OVFIE) | (udf & UDFIE).

Behaviour:
- Reset (preset=1 at a rising edge):
  - all TDR, TCR, TCNT and status = 0; prescaler = 0.
  - prdata=0, pslverr=0, tmr_ovf=0, tmr_udf=0, irq=0; pready=1 always.
- Register map, offset within a channel:
  - 0 TDR: reload/load value, R/W.
  - 1 TCR: control, R/W.
  - 2 TSR: bit0 OVF, bit1 UDF; write-1-to-clear.
  - 3 TCNT: live count, read-only.
- TCR bits:
  - 7 LOAD: strobe, always reads 0.
  - 6 ARLD: auto-reload.
  - 5 DOWN: 1 = count down.
  - 4 EN.
  - 3 OVFIE; 2 UDFIE.
  - 1:0 CS: clock select.
  - Bits above 7 read 0.
- APB transfer:
  - A write commits at the rising edge where psel & penable & pwrite.
  - Reads: prdata is combinational while psel & !pwrite; it is 0 otherwise.
  - pslverr=1 during the access phase when the channel index >= NUM_CH, or on a write to TCNT. The access has no effect and the read returns 0.
- Prescaler:
  - pc is a 4-bit free-running counter; +1 every pclk, wraps 15 -> 0.
  - Channel tick when pc[CS:0] are all 1, i.e. a period of 2^(CS+1) cycles (CS 0..3 = /2, /4, /8, /16).
  - Ticks are phase-aligned across channels.
- Counter update, per channel per edge, in priority order:
  1. LOAD written as 1: TCNT <= pwdata-independent current TDR value (the TDR written before this cycle). Any tick in that cycle is ignored.
  2. EN=1 and tick, up mode: at TCNT = 2^DATA_WIDTH-1, TCNT <= (ARLD ? TDR : 0) and OVF is set; otherwise TCNT+1.
  3. EN=1 and tick, down mode: at TCNT = 0, TCNT <= (ARLD ? TDR : all-ones) and UDF is set; otherwise TCNT-1.
  4. Otherwise TCNT holds.
- Status flags:
  - OVF/UDF are sticky until W1C.
  - A hardware set in the same cycle as a W1C clear wins: the flag stays 1.
  - tmr_ovf[i] / tmr_udf[i] are the registered flags, visible the cycle after the event edge.
  - irq is combinational from flags and enables.
- EN cleared: count freezes immediately; flags retained.
- Changing CS or DOWN while enabled takes effect from the next edge; no count is lost or duplicated.
- A synchronous reset mid-count returns everything to the reset state on that edge; the prescaler restarts at 0.

Test Plan:
- Reset, then read all 4 registers of ch0 and ch1 -> all 0; pready=1, pslverr=0.
- ch0: TDR=0xFA, TCR=0x80 (load), then TCR=0x10 (EN, CS=0, up) -> TCNT reaches 0xFF after 10 pclk. tmr_ovf[0] rises 2 cycles later and TCNT=0x00.
- ch1: TDR=0x03, TCR=0xE1 (load, ARLD, DOWN, CS=1), then TCR=0x75 (ARLD, DOWN, EN, UDFIE, CS=1) -> decrements every 4 pclk: 3, 2, 1, 0, then reloads to 3. tmr_udf[1]=1 and irq=1 on underflow; ch0 is unaffected.
- W1C: write TSR=0x01 on ch0 in the same cycle an overflow occurs -> OVF remains 1. A later write of TSR=0x01 -> OVF=0 and irq drops.
- Write TCNT, or any access with channel index >= NUM_CH -> pslverr=1; register contents unchanged; read returns 0.
- Assert preset mid-count on ch1 (TCNT=0x02) -> next cycle TCNT=0, TCR=0, flags=0; counting does not resume until reprogrammed.
